// File: rtl/sfx_pkg.sv
// Shared types and default hold durations for the
// sound-effect request controller.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        JUMP,
        WIN,
        LOSE
    } sfx_state_t;

    typedef enum logic [1:0] {
        DIR_FWD,
        DIR_BACK,
        DIR_RIGHT,
        DIR_LEFT
    } jump_dir_t;

    // 50 MHz clock: 50 ms jump, 1 s win, 0.8 s lose
    localparam int unsigned DEF_JUMP_CYCLES = 2_500_000;
    localparam int unsigned DEF_WIN_CYCLES  = 50_000_000;
    localparam int unsigned DEF_LOSE_CYCLES = 40_000_000;

endpackage

// File: rtl/sfx_dur_counter.sv
// Loadable down-counter that measures how long a
// request has left to be held; stops at zero.
module sfx_dur_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] remain;

    // clear wins over load; otherwise count down to zero and hold
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (!zero) begin
            remain <= remain - 1'b1;
        end
    end

    assign zero = (remain == '0);

endmodule

// File: rtl/sfx_request_ctrl.sv
// Stretches one-cycle game events into held, mutually
// exclusive audio requests with priority and pre-emption.
module sfx_request_ctrl
    import sfx_pkg::*;
#(
    parameter int unsigned JUMP_CYCLES = DEF_JUMP_CYCLES,
    parameter int unsigned WIN_CYCLES  = DEF_WIN_CYCLES,
    parameter int unsigned LOSE_CYCLES = DEF_LOSE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic mute,
    input  logic fwd_evt,
    input  logic back_evt,
    input  logic right_evt,
    input  logic left_evt,
    input  logic win_evt,
    input  logic lose_evt,
    output logic jumpForward,
    output logic jumpBackward,
    output logic jumpRight,
    output logic jumpLeft,
    output logic win,
    output logic lose,
    output logic busy
);

    localparam int unsigned MAX_JW =
        (JUMP_CYCLES > WIN_CYCLES) ? JUMP_CYCLES : WIN_CYCLES;
    localparam int unsigned MAX_ALL =
        (MAX_JW > LOSE_CYCLES) ? MAX_JW : LOSE_CYCLES;
    localparam int unsigned CW =
        (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] JUMP_LOAD = CW'(JUMP_CYCLES - 1);
    localparam logic [CW-1:0] WIN_LOAD  = CW'(WIN_CYCLES - 1);
    localparam logic [CW-1:0] LOSE_LOAD = CW'(LOSE_CYCLES - 1);

    sfx_state_t    state;
    sfx_state_t    stateNext;
    jump_dir_t     dir;
    jump_dir_t     dirNext;
    jump_dir_t     evtDir;
    logic          anyJump;
    logic          cntLoad;
    logic [CW-1:0] cntLoadVal;
    logic          cntZero;

    sfx_dur_counter #(
        .W(CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (mute),
        .load     (cntLoad),
        .load_val (cntLoadVal),
        .zero     (cntZero)
    );

    // hop priority: fwd > back > right > left
    always_comb begin
        anyJump = fwd_evt | back_evt | right_evt | left_evt;
        evtDir  = DIR_LEFT;
        if (fwd_evt) begin
            evtDir = DIR_FWD;
        end else if (back_evt) begin
            evtDir = DIR_BACK;
        end else if (right_evt) begin
            evtDir = DIR_RIGHT;
        end
    end

    // state and direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dir   <= DIR_FWD;
        end else begin
            state <= stateNext;
            dir   <= dirNext;
        end
    end

    // next state: lose > win > jump; only IDLE and JUMP accept
    always_comb begin
        stateNext  = state;
        dirNext    = dir;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        if (mute) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE, JUMP: begin
                    if (lose_evt) begin
                        stateNext  = LOSE;
                        cntLoad    = 1'b1;
                        cntLoadVal = LOSE_LOAD;
                    end else if (win_evt) begin
                        stateNext  = WIN;
                        cntLoad    = 1'b1;
                        cntLoadVal = WIN_LOAD;
                    end else if (anyJump) begin
                        stateNext  = JUMP;
                        dirNext    = evtDir;
                        cntLoad    = 1'b1;
                        cntLoadVal = JUMP_LOAD;
                    end else if (cntZero) begin
                        stateNext = IDLE;
                    end
                end
                WIN, LOSE: begin
                    if (cntZero) begin
                        stateNext = IDLE;
                    end
                end
            endcase
        end
    end

    // outputs decode registered state only
    assign jumpForward  = (state == JUMP) && (dir == DIR_FWD);
    assign jumpBackward = (state == JUMP) && (dir == DIR_BACK);
    assign jumpRight    = (state == JUMP) && (dir == DIR_RIGHT);
    assign jumpLeft     = (state == JUMP) && (dir == DIR_LEFT);
    assign win          = (state == WIN);
    assign lose         = (state == LOSE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sfx_request_ctrl.sv
// Directed scoreboard bench for sfx_request_ctrl with
// short hold durations (jump 4, win 8, lose 6).
module tb_sfx_request_ctrl;

    localparam int LEN = 32;

    // event bits
    localparam int E_RST   = 7;
    localparam int E_MUTE  = 6;
    localparam int E_FWD   = 5;
    localparam int E_BACK  = 4;
    localparam int E_RIGHT = 3;
    localparam int E_LEFT  = 2;
    localparam int E_WIN   = 1;
    localparam int E_LOSE  = 0;

    // output bits
    localparam int O_JF   = 6;
    localparam int O_JB   = 5;
    localparam int O_JR   = 4;
    localparam int O_JL   = 3;
    localparam int O_WIN  = 2;
    localparam int O_LOSE = 1;

    typedef struct {
        string      name;
        int         cyc;
        logic [6:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mute = 1'b0;
    logic fwdEvt = 1'b0;
    logic backEvt = 1'b0;
    logic rightEvt = 1'b0;
    logic leftEvt = 1'b0;
    logic winEvt = 1'b0;
    logic loseEvt = 1'b0;
    logic jumpForward;
    logic jumpBackward;
    logic jumpRight;
    logic jumpLeft;
    logic win;
    logic lose;
    logic busy;

    exp_t       sb[$];
    logic [7:0] evt[LEN];
    logic [6:0] expv[LEN];
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    sfx_request_ctrl #(
        .JUMP_CYCLES(4),
        .WIN_CYCLES (8),
        .LOSE_CYCLES(6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mute        (mute),
        .fwd_evt     (fwdEvt),
        .back_evt    (backEvt),
        .right_evt   (rightEvt),
        .left_evt    (leftEvt),
        .win_evt     (winEvt),
        .lose_evt    (loseEvt),
        .jumpForward (jumpForward),
        .jumpBackward(jumpBackward),
        .jumpRight   (jumpRight),
        .jumpLeft    (jumpLeft),
        .win         (win),
        .lose        (lose),
        .busy        (busy)
    );

    function automatic void clearTables();
        for (int c = 0; c < LEN; c++) begin
            evt[c]  = '0;
            expv[c] = '0;
        end
        evt[0][E_RST] = 1'b1;
        evt[1][E_RST] = 1'b1;
    endfunction

    function automatic void addEvt(int c, int b);
        evt[c][b] = 1'b1;
    endfunction

    function automatic void addHigh(int b, int lo, int hi);
        for (int c = lo; c <= hi; c++) begin
            expv[c][b] = 1'b1;
            expv[c][0] = 1'b1;
        end
    endfunction

    // drive one cycle per iteration, queue the expected outputs
    task automatic runTest(input string nm);
        for (int c = 0; c < LEN; c++) begin
            @(posedge clk);
            #1;
            reset    = evt[c][E_RST];
            mute     = evt[c][E_MUTE];
            fwdEvt   = evt[c][E_FWD];
            backEvt  = evt[c][E_BACK];
            rightEvt = evt[c][E_RIGHT];
            leftEvt  = evt[c][E_LEFT];
            winEvt   = evt[c][E_WIN];
            loseEvt  = evt[c][E_LOSE];
            if (c >= 2) begin
                sb.push_back('{nm, c, expv[c]});
            end
        end
    endtask

    // monitor: compare sampled outputs against queue head
    always @(negedge clk) begin
        logic [6:0] outs;
        exp_t       e;
        outs = {jumpForward, jumpBackward, jumpRight,
                jumpLeft, win, lose, busy};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (outs === e.exp) begin
                passes++;
            end else begin
                $display("FAIL %s cyc %0d: got %b want %b",
                         e.name, e.cyc, outs, e.exp);
            end
            checks++;
            if ($countones(outs[6:1]) <= 1 &&
                outs[0] === (|outs[6:1])) begin
                passes++;
            end else begin
                $display("FAIL %s_onehot cyc %0d: got %b want <=1 hot, busy=or",
                         e.name, e.cyc, outs);
            end
        end
    end

    initial begin
        clearTables();
        addEvt(10, E_FWD);
        addHigh(O_JF, 11, 14);
        runTest("fwd");

        clearTables();
        addEvt(10, E_RIGHT);
        addEvt(14, E_LEFT);
        addHigh(O_JR, 11, 14);
        addHigh(O_JL, 15, 18);
        runTest("retrigger");

        clearTables();
        addEvt(10, E_BACK);
        addEvt(12, E_LOSE);
        addHigh(O_JB, 11, 12);
        addHigh(O_LOSE, 13, 18);
        runTest("preempt");

        clearTables();
        addEvt(10, E_WIN);
        addEvt(10, E_FWD);
        addEvt(13, E_LOSE);
        addHigh(O_WIN, 11, 18);
        runTest("win_prio");

        clearTables();
        addEvt(10, E_LOSE);
        addEvt(12, E_RST);
        addEvt(14, E_FWD);
        addHigh(O_LOSE, 11, 12);
        addHigh(O_JF, 15, 18);
        runTest("reset_mid");

        clearTables();
        for (int c = 10; c <= 20; c++) begin
            addEvt(c, E_MUTE);
        end
        addEvt(12, E_FWD);
        addEvt(15, E_WIN);
        addEvt(21, E_WIN);
        addHigh(O_WIN, 22, 29);
        runTest("mute");

        clearTables();
        addEvt(10, E_WIN);
        addEvt(18, E_FWD);
        addEvt(19, E_BACK);
        addHigh(O_WIN, 11, 18);
        addHigh(O_JB, 20, 23);
        runTest("win_end");

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
